// File: rtl/sample_clk_ctrl.sv
// sample_clk_ctrl: run control and rate configuration for the sample-clock divider.
// Produces a 50%-duty divided clock (newclk), a tick on each rising edge of it,
// and applies half-period changes only on half-period boundaries so the output
// never glitches.
module sample_clk_ctrl #(
    parameter int CNT_W        = 16,
    parameter int DEFAULT_HALF = 100,
    parameter int BURST_W      = 8
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               start,
    input  logic               stop,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               cfg_valid,
    input  logic [CNT_W-1:0]   cfg_half,
    output logic               cfg_ready,
    output logic               newclk,
    output logic               tick,
    output logic               busy,
    output logic               burst_done,
    output logic [CNT_W-1:0]   half_cur,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   pend_half;
    logic               pend_v;
    logic [BURST_W-1:0] remaining;
    logic               burst_mode;

    logic               cfg_accept;
    logic [CNT_W-1:0]   cfg_clamped;
    logic               boundary;
    logic               burst_final;
    logic               clean_end;
    logic               quick_stop;

    // Config handshake: a value transfers on any rising clk edge where
    // cfg_valid && cfg_ready. cfg_ready depends only on state and pend_v
    // (never on cfg_valid), so the offerer may hold cfg_valid/cfg_half until
    // it sees the transfer. In IDLE the value lands directly in half_cur;
    // while running it is parked in pend_half until the next boundary.
    assign cfg_ready   = (state == IDLE) || !pend_v;
    assign cfg_accept  = cfg_valid && cfg_ready;
    // A half-period below 2 would make newclk degenerate; clamp it.
    assign cfg_clamped = (cfg_half < CNT_W'(2)) ? CNT_W'(2) : cfg_half;

    assign boundary    = (state != IDLE) && (cnt == half_cur - CNT_W'(1));
    assign burst_final = burst_mode && (remaining == '0);
    // Falling boundary is the only clean place to stop once newclk is high.
    assign clean_end   = boundary && newclk &&
                         (burst_final || stop || (state == STOPPING));
    // With newclk low there is no half pulse to protect; stop at once.
    assign quick_stop  = (state == RUN) && stop && !newclk;

    assign state_dbg   = state;

    // Run-control FSM, half-period counter, divided clock and config apply.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            cnt        <= '0;
            pend_v     <= 1'b0;
            pend_half  <= '0;
            remaining  <= '0;
            burst_mode <= 1'b0;
            newclk     <= 1'b0;
            tick       <= 1'b0;
            busy       <= 1'b0;
            burst_done <= 1'b0;
            half_cur   <= CNT_W'(DEFAULT_HALF);
        end else begin
            tick       <= 1'b0;
            burst_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_accept) begin
                        half_cur <= cfg_clamped;
                    end
                    // stop in the same cycle as start keeps us idle
                    if (start && !stop) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        cnt        <= '0;
                        newclk     <= 1'b0;
                        remaining  <= burst_len;
                        burst_mode <= (burst_len != '0);
                    end
                end
                RUN, STOPPING: begin
                    if (boundary) begin
                        cnt    <= '0;
                        newclk <= !newclk;
                        if (pend_v) begin
                            half_cur <= pend_half;
                            pend_v   <= 1'b0;
                        end
                        if (!newclk) begin
                            tick <= 1'b1;
                            if (burst_mode) begin
                                remaining <= remaining - BURST_W'(1);
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    // cfg_ready is low while pend_v is set, so this never
                    // collides with the boundary apply above.
                    if (cfg_accept) begin
                        pend_half <= cfg_clamped;
                        pend_v    <= 1'b1;
                    end
                    if (clean_end || quick_stop) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        cnt        <= '0;
                        newclk     <= 1'b0;
                        tick       <= 1'b0;
                        burst_mode <= 1'b0;
                        remaining  <= '0;
                        pend_v     <= 1'b0;
                        burst_done <= clean_end && burst_final;
                        // leaving the run, any parked rate takes effect now
                        if (pend_v) begin
                            half_cur <= pend_half;
                        end else if (cfg_accept) begin
                            half_cur <= cfg_clamped;
                        end
                    end else if ((state == RUN) && stop) begin
                        state <= STOPPING;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_clk_ctrl.sv
// Bench for sample_clk_ctrl: directed test-plan sequences plus random traffic,
// all checked cycle by cycle through an expected-value queue.
module tb_sample_clk_ctrl;

    localparam int CNT_W   = 16;
    localparam int BURST_W = 8;
    localparam int W       = 5 + CNT_W;

    logic               clk;
    logic               nrst;
    logic               start;
    logic               stop;
    logic [BURST_W-1:0] burst_len;
    logic               cfg_valid;
    logic [CNT_W-1:0]   cfg_half;
    logic               cfg_ready;
    logic               newclk;
    logic               tick;
    logic               busy;
    logic               burst_done;
    logic [CNT_W-1:0]   half_cur;
    logic [1:0]         state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    sample_clk_ctrl #(.CNT_W(CNT_W), .DEFAULT_HALF(100), .BURST_W(BURST_W)) dut (
        .clk(clk), .nrst(nrst), .start(start), .stop(stop), .burst_len(burst_len),
        .cfg_valid(cfg_valid), .cfg_half(cfg_half), .cfg_ready(cfg_ready),
        .newclk(newclk), .tick(tick), .busy(busy), .burst_done(burst_done),
        .half_cur(half_cur), .state_dbg(state_dbg)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (time-based view of the divider) -----
    bit m_active, m_stopping, m_high, m_burst, m_pend;
    int m_half, m_pend_half, m_elapsed, m_left;

    task automatic model_reset();
        m_active = 0; m_stopping = 0; m_high = 0; m_burst = 0; m_pend = 0;
        m_half = 100; m_pend_half = 0; m_elapsed = 0; m_left = 0;
        exp_q.delete();
    endtask

    // Advance the model by one clk edge with the given inputs and return the
    // outputs expected just after that edge.
    task automatic model_step(input bit st, input bit sp, input int bl,
                              input bit cv, input int ch, output logic [W-1:0] e);
        bit rdy, acc, tk, dn, fin, at_b, was_high;
        int v;
        rdy = !m_active || !m_pend;
        acc = cv && rdy;
        v   = (ch < 2) ? 2 : ch;
        tk = 0; dn = 0; fin = 0;
        if (!m_active) begin
            if (acc) m_half = v;
            if (st && !sp) begin
                m_active = 1; m_stopping = 0; m_high = 0; m_elapsed = 0;
                m_left = bl; m_burst = (bl != 0);
            end
        end else begin
            at_b     = (m_elapsed + 1 == m_half);
            was_high = m_high;
            if (at_b) begin
                m_high = !m_high;
                m_elapsed = 0;
                if (m_pend) begin m_half = m_pend_half; m_pend = 0; end
                if (!was_high) begin
                    tk = 1;
                    if (m_burst) m_left--;
                end else if (m_stopping || sp || (m_burst && m_left == 0)) begin
                    fin = 1;
                    dn  = m_burst && (m_left == 0);
                end
            end else begin
                m_elapsed++;
            end
            if (acc) begin m_pend = 1; m_pend_half = v; end
            if (!fin && sp && !m_stopping) begin
                if (was_high) m_stopping = 1;
                else begin fin = 1; tk = 0; end
            end
            if (fin) begin
                m_active = 0; m_stopping = 0; m_high = 0; m_elapsed = 0;
                m_burst = 0; m_left = 0;
                if (m_pend) m_half = m_pend_half;
                m_pend = 0;
            end
        end
        e = {m_high, tk, m_active, dn, (!m_active || !m_pend), CNT_W'(m_half)};
    endtask

    // ---------------- driver tasks ----------------------------------------
    task automatic step(input bit st, input bit sp, input int bl,
                        input bit cv, input int ch);
        logic [W-1:0] e;
        @(negedge clk);
        start = st; stop = sp; burst_len = BURST_W'(bl);
        cfg_valid = cv; cfg_half = CNT_W'(ch);
        model_step(st, sp, bl, cv, ch, e);
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        start = 0; stop = 0; burst_len = '0; cfg_valid = 0; cfg_half = '0;
    endtask

    // Asynchronous reset asserted between edges, checked before any clk edge.
    task automatic async_reset();
        #2;
        nrst = 0;
        clear_inputs();
        #1;
        chk("rst_newclk", newclk, 0);
        chk("rst_tick", tick, 0);
        chk("rst_busy", busy, 0);
        chk("rst_burst_done", burst_done, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_half_cur", half_cur, 100);
        model_reset();
        repeat (3) @(negedge clk);
        nrst = 1;
    endtask

    // ---------------- scoreboard monitor ----------------------------------
    always @(posedge clk) begin
        logic [W-1:0] act, e;
        #1;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            act = {newclk, tick, busy, burst_done, cfg_ready, half_cur};
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL scoreboard {newclk,tick,busy,done,ready,half}: got %h expected %h at %0t",
                         act, e, $time);
            end
        end
    end

    // ---------------- stimulus --------------------------------------------
    initial begin
        int ticks;
        nrst = 0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        chk("init_half_cur", half_cur, 100);
        chk("init_busy", busy, 0);
        nrst = 1;

        // 1: free run at default half 100
        step(1, 0, 0, 0, 0);
        #1 chk("t1_busy_E0", busy, 1);
        for (int k = 1; k <= 300; k++) begin
            idle_step();
            #1;
            if (k == 99)  chk("t1_newclk_99", newclk, 0);
            if (k == 100) begin chk("t1_newclk_100", newclk, 1); chk("t1_tick_100", tick, 1); end
            if (k == 101) chk("t1_tick_101", tick, 0);
            if (k == 200) chk("t1_newclk_200", newclk, 0);
            if (k == 300) begin chk("t1_newclk_300", newclk, 1); chk("t1_tick_300", tick, 1); end
        end
        step(0, 1, 0, 0, 0);
        repeat (220) idle_step();

        // 2: burst of 3
        ticks = 0;
        step(1, 0, 3, 0, 0);
        for (int k = 1; k <= 700; k++) begin
            idle_step();
            #1;
            if (tick) ticks++;
            if (k == 599) chk("t2_done_599", burst_done, 0);
            if (k == 600) chk("t2_done_600", burst_done, 1);
        end
        chk("t2_tick_count", ticks, 3);
        chk("t2_busy_after", busy, 0);
        chk("t2_newclk_after", newclk, 0);

        // 3: rate change mid-run
        step(1, 0, 0, 0, 0);
        repeat (29) idle_step();
        step(0, 0, 0, 1, 50);
        #1 chk("t3_ready_31", cfg_ready, 0);
        for (int k = 31; k <= 150; k++) begin
            idle_step();
            #1;
            if (k == 99)  chk("t3_ready_99", cfg_ready, 0);
            if (k == 100) begin chk("t3_ready_100", cfg_ready, 1); chk("t3_half_100", half_cur, 50); end
            if (k == 149) chk("t3_newclk_149", newclk, 1);
            if (k == 150) chk("t3_newclk_150", newclk, 0);
        end
        step(0, 1, 0, 0, 0);
        repeat (120) idle_step();
        step(0, 0, 0, 1, 1);
        #1 chk("t3_clamp", half_cur, 2);
        step(0, 0, 0, 1, 100);

        // 4: stop while high, then stop while low
        step(1, 0, 0, 0, 0);
        repeat (149) idle_step();
        step(0, 1, 0, 0, 0);
        for (int k = 151; k <= 200; k++) begin
            idle_step();
            #1;
            if (k == 199) chk("t4_busy_199", busy, 1);
            if (k == 200) begin chk("t4_busy_200", busy, 0); chk("t4_newclk_200", newclk, 0); end
        end
        step(1, 0, 0, 0, 0);
        repeat (49) idle_step();
        step(0, 1, 0, 0, 0);
        #1 chk("t4_busy_low_stop", busy, 0);
        repeat (5) idle_step();

        // 5: start and stop together from IDLE
        step(1, 1, 0, 0, 0);
        #1 chk("t5_busy", busy, 0);
        repeat (120) idle_step();

        // 6: asynchronous reset mid-run, then clean restart
        step(1, 0, 0, 0, 0);
        repeat (120) idle_step();
        async_reset();
        repeat (20) idle_step();
        step(1, 0, 0, 0, 0);
        for (int k = 1; k <= 100; k++) begin
            idle_step();
            #1;
            if (k == 100) chk("t6_tick_100", tick, 1);
        end
        step(0, 1, 0, 0, 0);
        repeat (220) idle_step();
        step(0, 0, 0, 1, 6);

        // random traffic with short half-periods
        for (int k = 0; k < 4000; k++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0,
                 int'($urandom_range(0, 4)), $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 20)));
        end
        repeat (4) idle_step();
        #2;
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
